// File: rtl/ysyx_24110015_lsu.sv
// Multi-cycle load/store unit between EXU and write-back.
// One transaction in flight on a valid/ready memory bus; loads are aligned and extended here.
module ysyx_24110015_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_wdata,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic [2:0]  in_memop,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_wen,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [31:0] resp_rdata,
  input  logic        resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2, S_DONE = 2'd3} state_e;

  state_e      state_q, state_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  memop_q, memop_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wen_q, wen_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  // Undefined memop encodings are folded into the misaligned error path.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = a[0];
      3'b010:         misaligned = (a != 2'b00);
      default:        misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] d);
    case (op[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] op, input logic [1:0] a);
    case (op[1:0])
      2'b00:   store_strb = 4'b0001 << a;
      2'b01:   store_strb = 4'b0011 << a;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {a, 3'b000};
    case (op[1:0])
      2'b00:   load_extract = {{24{~op[2] & sh[7]}}, sh[7:0]};
      2'b01:   load_extract = {{16{~op[2] & sh[15]}}, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  // Next-state and captured-field logic.
  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    memop_d   = memop_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wen_d     = wen_q;
    data_d    = data_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d    = in_alu;
          memop_d   = in_memop;
          is_load_d = in_memread;
          wen_d     = in_memwrite & ~in_memread;
          wdata_d   = store_data(in_memop, in_wdata);
          wstrb_d   = in_memread ? 4'b0000 : store_strb(in_memop, in_alu[1:0]);
          if (!(in_memread | in_memwrite)) begin
            state_d = S_DONE;
            data_d  = in_alu;
            err_d   = 1'b0;
          end else if (misaligned(in_memop, in_alu[1:0])) begin
            state_d = S_DONE;
            data_d  = 32'h0000_0000;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          state_d = S_RESP;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RESP: begin
        if (resp_valid) begin
          state_d = S_DONE;
          err_d   = resp_err;
          data_d  = (resp_err | ~is_load_q) ? 32'h0000_0000
                                            : load_extract(memop_q, addr_q[1:0], resp_rdata);
        end else begin
          state_d = S_RESP;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and transaction registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      is_load_q <= 1'b0;
      memop_q   <= 3'b000;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'b0000;
      wen_q     <= 1'b0;
      data_q    <= 32'h0000_0000;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      memop_q   <= memop_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wen_q     <= wen_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  // Handshake outputs come from the state register; in_ready is also held low while in reset.
  assign in_ready   = (state_q == S_IDLE) & rst;
  assign req_valid  = (state_q == S_REQ);
  assign resp_ready = (state_q == S_RESP);
  assign out_valid  = (state_q == S_DONE);
  assign req_wen    = wen_q;
  assign req_addr   = addr_q;
  assign req_wdata  = wdata_q;
  assign req_wstrb  = wstrb_q;
  assign out_data   = data_q;
  assign out_err    = err_q;
endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Directed bench for ysyx_24110015_lsu: transaction-level model plus per-cycle comparison.
module tb_ysyx_24110015_lsu;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_memread, in_memwrite;
  logic [31:0] in_alu, in_wdata;
  logic [2:0]  in_memop;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_data;

  int n_cmp = 0;
  int n_fail = 0;

  logic        exp_has_req = 1'b0, exp_wen = 1'b0, exp_out_err = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_out_data = '0;
  logic [3:0]  exp_wstrb = '0;

  ysyx_24110015_lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_alu(in_alu),
    .in_wdata(in_wdata), .in_memread(in_memread), .in_memwrite(in_memwrite), .in_memop(in_memop),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b", name, act, req);
    end
  endtask

  // Instruction-level model: bus request and result follow from size, offset and sign rules.
  task automatic model(input logic [31:0] alu, input logic [31:0] wd, input logic rd, input logic wr,
                       input logic [2:0] op, input logic [31:0] rdata, input logic rerr);
    int unsigned size, a, range, div, t;
    logic [31:0] v;
    a = alu % 4;
    exp_addr = alu; exp_wen = wr && !rd; exp_has_req = 1'b0; exp_wdata = '0; exp_wstrb = '0;
    case (op)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (!rd && !wr) begin
      exp_out_data = alu; exp_out_err = 1'b0;
    end else if (size == 0 || (alu % size) != 0) begin
      exp_out_data = '0; exp_out_err = 1'b1;
    end else begin
      exp_has_req = 1'b1;
      if (!rd) begin
        if (size == 1) begin
          exp_wdata = (wd % 256) * 32'h0101_0101; t = 1 << a;
        end else if (size == 2) begin
          exp_wdata = (wd % 65536) * 32'h0001_0001; t = 3 << a;
        end else begin
          exp_wdata = wd; t = 15;
        end
        exp_wstrb = t[3:0];
      end
      if (rerr) begin
        exp_out_data = '0; exp_out_err = 1'b1;
      end else if (!rd) begin
        exp_out_data = '0; exp_out_err = 1'b0;
      end else begin
        exp_out_err = 1'b0;
        if (size == 4) v = rdata;
        else begin
          range = 1 << (8 * size);
          div = 1 << (8 * a);
          v = (rdata / div) % range;
          if (op < 3'd4 && v >= range / 2) v = v - range;
        end
        exp_out_data = v;
      end
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model's expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (req_valid) begin
        chkb("req_allowed", req_valid, exp_has_req);
        chk("req_addr", req_addr, exp_addr);
        chkb("req_wen", req_wen, exp_wen);
        chk("req_wstrb", {28'd0, req_wstrb}, {28'd0, exp_wstrb});
        if (exp_wen) chk("req_wdata", req_wdata, exp_wdata);
      end
      if (out_valid) begin
        chk("out_data", out_data, exp_out_data);
        chkb("out_err", out_err, exp_out_err);
      end
      chkb("ready_exclusive", in_ready & (req_valid | resp_ready | out_valid), 1'b0);
    end
  end

  task automatic run_op(input string nm, input logic [31:0] alu, input logic [31:0] wd,
                        input logic rd, input logic wr, input logic [2:0] op,
                        input logic [31:0] rdata, input logic rerr, input int rw, input int sw,
                        input int ow, output logic [31:0] g_data, output logic g_err,
                        output logic [31:0] g_wdata, output logic [3:0] g_wstrb,
                        output logic g_wen, output int g_lat);
    int nreq, rcnt, ocnt, k;
    bit done;
    nreq = 0; rcnt = 0; ocnt = 0; done = 1'b0; g_lat = 0;
    g_data = '0; g_err = 1'b0; g_wdata = '0; g_wstrb = '0; g_wen = 1'b0;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chkb({nm, "_in_ready"}, in_ready, 1'b1);
    model(alu, wd, rd, wr, op, rdata, rerr);
    in_valid = 1'b1; in_alu = alu; in_wdata = wd; in_memread = rd; in_memwrite = wr; in_memop = op;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      if (out_valid && g_lat == 0) begin
        g_lat = c; g_data = out_data; g_err = out_err;
      end
      if (req_valid) begin
        if (nreq == 0) begin
          g_wdata = req_wdata; g_wstrb = req_wstrb; g_wen = req_wen;
        end
        nreq++;
        req_ready = (nreq > rw);
        resp_valid = 1'b1; resp_rdata = 32'hBAD0_BAD0; resp_err = 1'b1;
      end else if (resp_ready) begin
        req_ready = 1'b0;
        resp_valid = (rcnt >= sw); rcnt++;
        resp_rdata = rdata; resp_err = rerr;
      end else begin
        req_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0;
      end
      if (out_valid) begin
        out_ready = (ocnt >= ow); ocnt++;
      end else begin
        out_ready = 1'b0;
      end
      @(posedge clk);
      done = out_ready;
      #1;
      req_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0; out_ready = 1'b0;
    end
    chkb({nm, "_done"}, done, 1'b1);
    chk({nm, "_lat"}, g_lat, exp_has_req ? 3 + rw + sw : 1);
    chk({nm, "_nreq"}, nreq, exp_has_req ? rw + 1 : 0);
    @(negedge clk);
    chkb({nm, "_bubble_in_ready"}, in_ready, 1'b1);
    chkb({nm, "_bubble_out_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] d, wdv;
    logic        e, we;
    logic [3:0]  ws;
    int          lat;
    rst = 1'b0; in_valid = 1'b0; in_alu = '0; in_wdata = '0; in_memread = 1'b0; in_memwrite = 1'b0;
    in_memop = 3'b000; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0; resp_err = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("rst_in_ready", in_ready, 1'b0);
    chkb("rst_req_valid", req_valid, 1'b0);
    chkb("rst_req_wen", req_wen, 1'b0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_req_wdata", req_wdata, 32'h0);
    chk("rst_req_wstrb", {28'd0, req_wstrb}, 32'h0);
    chkb("rst_resp_ready", resp_ready, 1'b0);
    chkb("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chkb("rst_out_err", out_err, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chkb("rel_in_ready", in_ready, 1'b1);

    run_op("alu", 32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 0, 0, 0, d, e, wdv, ws, we, lat);
    chk("alu_data", d, 32'h0000_1234); chkb("alu_err", e, 1'b0); chk("alu_lat", lat, 1);

    run_op("lb", 32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'b000, 32'h80FF_0000, 1'b0, 0, 0, 0, d, e, wdv, ws, we, lat);
    chk("lb_data", d, 32'hFFFF_FF80); chk("lb_wstrb", {28'd0, ws}, 32'h0); chk("lb_lat", lat, 3);

    run_op("lbu", 32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'b100, 32'h80FF_0000, 1'b0, 0, 0, 0, d, e, wdv, ws, we, lat);
    chk("lbu_data", d, 32'h0000_0080);

    run_op("sh", 32'h8000_0002, 32'h1234_ABCD, 1'b0, 1'b1, 3'b001, 32'h0, 1'b0, 0, 0, 0, d, e, wdv, ws, we, lat);
    chk("sh_wdata", wdv, 32'hABCD_ABCD); chk("sh_wstrb", {28'd0, ws}, 32'hC);
    chkb("sh_wen", we, 1'b1); chk("sh_data", d, 32'h0);

    run_op("lw_mis", 32'h8000_0002, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0, 1'b0, 0, 0, 0, d, e, wdv, ws, we, lat);
    chkb("lw_mis_err", e, 1'b1); chk("lw_mis_data", d, 32'h0); chk("lw_mis_lat", lat, 1);

    run_op("sw_wait", 32'h8000_0000, 32'h55AA_33CC, 1'b0, 1'b1, 3'b010, 32'h0, 1'b1, 3, 1, 2, d, e, wdv, ws, we, lat);
    chk("sw_wait_lat", lat, 7); chkb("sw_wait_err", e, 1'b1); chk("sw_wait_wstrb", {28'd0, ws}, 32'hF);

    run_op("lh", 32'h8000_0002, 32'h0, 1'b1, 1'b0, 3'b001, 32'h8001_7FFF, 1'b0, 1, 0, 0, d, e, wdv, ws, we, lat);
    chk("lh_data", d, 32'hFFFF_8001);

    run_op("lhu", 32'h8000_0000, 32'h0, 1'b1, 1'b0, 3'b101, 32'h8001_7FFF, 1'b0, 0, 2, 1, d, e, wdv, ws, we, lat);
    chk("lhu_data", d, 32'h0000_7FFF);

    run_op("sb", 32'h8000_0001, 32'h0000_00A5, 1'b0, 1'b1, 3'b000, 32'h0, 1'b0, 0, 0, 0, d, e, wdv, ws, we, lat);
    chk("sb_wstrb", {28'd0, ws}, 32'h2); chk("sb_wdata", wdv, 32'hA5A5_A5A5);

    run_op("bad_op", 32'h8000_0000, 32'h0, 1'b1, 1'b0, 3'b011, 32'h0, 1'b0, 0, 0, 0, d, e, wdv, ws, we, lat);
    chkb("bad_op_err", e, 1'b1);

    run_op("rdwr", 32'h8000_0004, 32'h1111_2222, 1'b1, 1'b1, 3'b010, 32'hCAFE_F00D, 1'b0, 0, 0, 0, d, e, wdv, ws, we, lat);
    chk("rdwr_data", d, 32'hCAFE_F00D); chkb("rdwr_wen", we, 1'b0);

    run_op("lw_err", 32'h8000_0008, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0000_1234, 1'b1, 0, 0, 0, d, e, wdv, ws, we, lat);
    chk("lw_err_data", d, 32'h0); chkb("lw_err_err", e, 1'b1);

    // Reset while a request is pending on the bus.
    model(32'h8000_0100, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0, 1'b0);
    in_valid = 1'b1; in_alu = 32'h8000_0100; in_memread = 1'b1; in_memwrite = 1'b0; in_memop = 3'b010;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chkb("rstreq_req_valid", req_valid, 1'b1);
    @(negedge clk);
    rst = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h1111_1111;
    @(negedge clk);
    chkb("rstreq_req_drop", req_valid, 1'b0);
    chkb("rstreq_out_valid", out_valid, 1'b0);
    chkb("rstreq_in_ready", in_ready, 1'b0);
    chkb("rstreq_resp_ready", resp_ready, 1'b0);
    rst = 1'b1; resp_valid = 1'b0;
    @(negedge clk);
    chkb("rstreq_rel_in_ready", in_ready, 1'b1);
    chkb("rstreq_rel_out_valid", out_valid, 1'b0);
    run_op("lw_after", 32'h8000_0010, 32'h0, 1'b1, 1'b0, 3'b010, 32'hDEAD_BEEF, 1'b0, 0, 0, 0, d, e, wdv, ws, we, lat);
    chk("lw_after_data", d, 32'hDEAD_BEEF); chkb("lw_after_err", e, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
